// File: rtl/rst_ctrl_pkg.sv
// Shared types for the SoC reset controller: FSM state encoding and counter sizing.
package rst_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_END     = 3'd4
    } rst_state_e;

    localparam int RUN_CNT_W = 32;

    // Width able to hold the larger of the two phase lengths.
    function automatic int cnt_width(input int hold_cycles, input int stagger_cycles);
        return $clog2(((hold_cycles > stagger_cycles) ? hold_cycles : stagger_cycles) + 1);
    endfunction

endpackage

// File: rtl/soc_reset_ctrl_if.sv
// Control/status bundle between the reset controller and the logic it sequences.
interface soc_reset_ctrl_if #(
    parameter int NUM_DOMAINS = 3
);
    import rst_ctrl_pkg::*;

    logic                   sw_rst_req;
    logic                   run_done;
    logic [NUM_DOMAINS-1:0] dom_rst;
    rst_state_e             state;
    logic [RUN_CNT_W-1:0]   run_cycles;
    logic                   done;
    logic                   timeout;

    modport master (
        output sw_rst_req, run_done,
        input  dom_rst, state, run_cycles, done, timeout
    );

    modport slave (
        input  sw_rst_req, run_done,
        output dom_rst, state, run_cycles, done, timeout
    );

endinterface

// File: rtl/soc_reset_ctrl_rst_sync.sv
// Reset-release synchronizer: asserts asynchronously, releases after STAGES clock edges.
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic rst_n_sync
);

    logic [STAGES-1:0] sync_q;

    // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(1);
        end
    end

    assign rst_n_sync = sync_q[STAGES-1];

endmodule

// File: rtl/soc_reset_ctrl.sv
// SoC reset sequencer: synchronized release, hold, staggered per-domain release, run watchdog.
module soc_reset_ctrl
    import rst_ctrl_pkg::*;
#(
    parameter int NUM_DOMAINS    = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 10,
    parameter int STAGGER_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic             clk,
    input  logic             rst,
    soc_reset_ctrl_if.slave  bus
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

    rst_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic [RUN_CNT_W-1:0]   run_cycles_q, run_cycles_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;

    logic                   rel_sync;
    logic [NUM_DOMAINS-1:0] dom_shift;
    logic [RUN_CNT_W-1:0]   run_inc;
    logic [CNT_W-1:0]       phase_last;

    // The RESET->HOLD transition acts as the final synchronizer stage, so the
    // FSM leaves RESET on exactly the SYNC_STAGES-th edge after release.
    rst_sync #(.STAGES(SYNC_STAGES - 1)) u_rst_sync (
        .clk        (clk),
        .rst_n      (rst),
        .rst_n_sync (rel_sync)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            dom_rst_q    <= '1;
            run_cycles_q <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dom_rst_q    <= dom_rst_d;
            run_cycles_q <= run_cycles_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    // Domains release lowest index first; the shift empties when the last one goes.
    assign dom_shift  = dom_rst_q << 1;
    assign run_inc    = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + 32'd1;
    assign phase_last = (state_q == ST_HOLD) ? HOLD_LAST : STAGGER_LAST;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves a latch behind.
        state_d      = state_q;
        cnt_d        = cnt_q;
        dom_rst_d    = dom_rst_q;
        run_cycles_d = run_cycles_q;
        done_d       = done_q;
        timeout_d    = timeout_q;

        if (state_q != ST_RESET && bus.sw_rst_req) begin
            state_d      = ST_HOLD;
            cnt_d        = '0;
            dom_rst_d    = '1;
            run_cycles_d = '0;
            done_d       = 1'b0;
            timeout_d    = 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (rel_sync) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD, ST_RELEASE: begin
                    if (cnt_q == phase_last) begin
                        cnt_d     = '0;
                        dom_rst_d = dom_shift;
                        state_d   = (dom_shift == '0) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    run_cycles_d = run_inc;
                    if (bus.run_done) begin
                        state_d = ST_END;
                        done_d  = 1'b1;
                    end else if (TIMEOUT_CYCLES != 0 && run_inc == 32'(TIMEOUT_CYCLES)) begin
                        state_d   = ST_END;
                        timeout_d = 1'b1;
                    end
                end
                ST_END: begin
                    dom_rst_d = '0;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.dom_rst    = dom_rst_q;
    assign bus.run_cycles = run_cycles_q;
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_soc_reset_ctrl.sv
// Directed bench for soc_reset_ctrl: default instance plus NUM_DOMAINS=1 / no-timeout variant.
module tb_soc_reset_ctrl;
    import rst_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst_v;
    int   vectors = 0;
    int   miscompares = 0;
    int   ecount = -1;

    always #5 clk = ~clk;

    soc_reset_ctrl_if #(.NUM_DOMAINS(3)) bus ();
    soc_reset_ctrl_if #(.NUM_DOMAINS(1)) bus_v ();

    soc_reset_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    soc_reset_ctrl #(.NUM_DOMAINS(1), .TIMEOUT_CYCLES(0)) u_dut_v (
        .clk (clk),
        .rst (rst_v),
        .bus (bus_v)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after absolute edge e (edge 0 = first edge after rst rises).
    task automatic run_to(input int e);
        repeat (e - ecount) @(posedge clk);
        ecount = e;
        @(negedge clk);
    endtask

    task automatic start_seq();
        @(negedge clk);
        rst    = 1'b1;
        ecount = -1;
    endtask

    task automatic check_main(input string tag, input logic [2:0] dom, input rst_state_e st);
        check({tag, "_dom"},   32'(bus.dom_rst), 32'(dom));
        check({tag, "_state"}, 32'(bus.state),   32'(st));
    endtask

    initial begin
        rst   = 1'b1;
        rst_v = 1'b1;
        bus.sw_rst_req   = 1'b0;
        bus.run_done     = 1'b0;
        bus_v.sw_rst_req = 1'b0;
        bus_v.run_done   = 1'b0;
        #2;
        rst   = 1'b0;
        rst_v = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        check_main("rst", 3'b111, ST_RESET);
        check("rst_cycles",  bus.run_cycles, 32'd0);
        check("rst_done",    32'(bus.done), 32'd0);
        check("rst_timeout", 32'(bus.timeout), 32'd0);

        // Nominal release then timeout; sw_rst_req during RESET is ignored
        start_seq();
        bus.sw_rst_req = 1'b1;
        run_to(0);
        bus.sw_rst_req = 1'b0;
        check_main("e0", 3'b111, ST_RESET);
        run_to(1);   check_main("e1", 3'b111, ST_HOLD);
        run_to(10);  check_main("e10", 3'b111, ST_HOLD);
        run_to(11);  check_main("e11", 3'b110, ST_RELEASE);
        run_to(14);  check_main("e14", 3'b110, ST_RELEASE);
        run_to(15);  check_main("e15", 3'b100, ST_RELEASE);
        run_to(18);  check_main("e18", 3'b100, ST_RELEASE);
        run_to(19);  check_main("e19", 3'b000, ST_RUN);
        check("e19_cycles", bus.run_cycles, 32'd0);
        run_to(20);  check("e20_cycles", bus.run_cycles, 32'd1);
        run_to(518);
        check_main("e518", 3'b000, ST_RUN);
        check("e518_cycles", bus.run_cycles, 32'd499);
        check("e518_timeout", 32'(bus.timeout), 32'd0);
        run_to(519);
        check_main("to", 3'b000, ST_END);
        check("to_cycles",  bus.run_cycles, 32'd500);
        check("to_timeout", 32'(bus.timeout), 32'd1);
        check("to_done",    32'(bus.done), 32'd0);
        run_to(530);
        check_main("to_hold", 3'b000, ST_END);
        check("to_hold_cycles",  bus.run_cycles, 32'd500);
        check("to_hold_timeout", 32'(bus.timeout), 32'd1);

        // Completion: run_done high before RUN is ignored, then sampled on 40th RUN edge
        rst = 1'b0;
        start_seq();
        run_to(1);
        bus.run_done = 1'b1;
        run_to(19);
        check_main("rd_ign", 3'b000, ST_RUN);
        check("rd_ign_done", 32'(bus.done), 32'd0);
        bus.run_done = 1'b0;
        run_to(58);
        bus.run_done = 1'b1;
        run_to(59);
        bus.run_done = 1'b0;
        check_main("cmp", 3'b000, ST_END);
        check("cmp_cycles",  bus.run_cycles, 32'd40);
        check("cmp_done",    32'(bus.done), 32'd1);
        check("cmp_timeout", 32'(bus.timeout), 32'd0);
        run_to(65);
        check("cmp_hold_done",   32'(bus.done), 32'd1);
        check("cmp_hold_cycles", bus.run_cycles, 32'd40);

        // sw_rst_req in END clears status
        bus.sw_rst_req = 1'b1;
        run_to(66);
        bus.sw_rst_req = 1'b0;
        check_main("sw_end", 3'b111, ST_HOLD);
        check("sw_end_done",   32'(bus.done), 32'd0);
        check("sw_end_cycles", bus.run_cycles, 32'd0);

        // sw_rst_req mid-RELEASE restarts the hold
        rst = 1'b0;
        start_seq();
        run_to(12);
        check_main("sw_pre", 3'b110, ST_RELEASE);
        bus.sw_rst_req = 1'b1;
        run_to(13);
        bus.sw_rst_req = 1'b0;
        check_main("sw_e13", 3'b111, ST_HOLD);
        run_to(22);  check_main("sw_e22", 3'b111, ST_HOLD);
        run_to(23);  check_main("sw_e23", 3'b110, ST_RELEASE);
        run_to(31);  check_main("sw_e31", 3'b000, ST_RUN);

        // Async reset mid-RUN, between edges, then full recovery
        run_to(33);
        #2;
        rst = 1'b0;
        #1;
        check_main("async", 3'b111, ST_RESET);
        check("async_cycles", bus.run_cycles, 32'd0);
        start_seq();
        run_to(0);   check_main("rec_e0", 3'b111, ST_RESET);
        run_to(1);   check_main("rec_e1", 3'b111, ST_HOLD);
        run_to(11);  check_main("rec_e11", 3'b110, ST_RELEASE);
        run_to(19);  check_main("rec_e19", 3'b000, ST_RUN);

        // Variant: single domain, timeout disabled
        check("v_rst_dom",   32'(bus_v.dom_rst), 32'd1);
        check("v_rst_state", 32'(bus_v.state), 32'(ST_RESET));
        @(negedge clk);
        rst_v  = 1'b1;
        ecount = -1;
        run_to(1);
        check("v_e1_state", 32'(bus_v.state), 32'(ST_HOLD));
        run_to(10);
        check("v_e10_dom",   32'(bus_v.dom_rst), 32'd1);
        check("v_e10_state", 32'(bus_v.state), 32'(ST_HOLD));
        run_to(11);
        check("v_e11_dom",   32'(bus_v.dom_rst), 32'd0);
        check("v_e11_state", 32'(bus_v.state), 32'(ST_RUN));
        run_to(10011);
        check("v_long_state",   32'(bus_v.state), 32'(ST_RUN));
        check("v_long_timeout", 32'(bus_v.timeout), 32'd0);
        check("v_long_cycles",  bus_v.run_cycles, 32'd10000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/soc_reset_ctrl.md
SOC_RESET_CTRL -- requirements
Module: soc_reset_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 3, number of independently released reset domains (1..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, reset-release synchronizer depth (>=2).
REQ-003 SHALL have parameter HOLD_CYCLES, default 10, cycles all domains stay in reset after synchronized release (>=1).
REQ-004 SHALL have parameter STAGGER_CYCLES, default 4, cycles between successive domain releases (>=1).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 500, RUN-phase cycle budget; 0 disables timeout.
REQ-006 SHALL have ports: clk input 1 system clock; rst input 1 reset, asynchronous, active-low.
REQ-007 SHALL have ports: sw_rst_req input 1 single-cycle request to re-run the reset sequence; run_done input 1 level, DUT reports completion.
REQ-008 SHALL have ports: dom_rst output NUM_DOMAINS per-domain reset, active-high (RstEnable polarity); state output 3 current FSM state.
REQ-009 SHALL have ports: run_cycles output 32 cycles spent in RUN; done output 1 completed via run_done; timeout output 1 budget exhausted.

Function
REQ-010 SHALL use FSM states RESET, HOLD, RELEASE, RUN, END.
REQ-011 SHALL leave RESET for HOLD on the first clk edge where the synchronized reset-release is high (SYNC_STAGES edges after rst rises).
REQ-012 SHALL, in HOLD, count HOLD_CYCLES edges, then deassert dom_rst[0] and enter RELEASE (RUN directly if NUM_DOMAINS=1).
REQ-013 SHALL, in RELEASE, deassert dom_rst[i] exactly STAGGER_CYCLES edges after dom_rst[i-1], in index order; the edge releasing the last domain enters RUN.
REQ-014 SHALL, in RUN, increment run_cycles each edge, saturating at 2^32-1; run_cycles holds its value in END.
REQ-015 SHALL enter END with done=1 on the edge run_done is sampled high in RUN; run_done outside RUN is ignored.
REQ-016 SHALL enter END with timeout=1 on the edge run_cycles reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES nonzero); run_done takes priority if both occur on the same edge.
REQ-017 SHALL keep all dom_rst deasserted in END; done/timeout are sticky until reset or sw_rst_req.
REQ-018 SHALL, on sw_rst_req in HOLD/RELEASE/RUN/END, assert all dom_rst, clear run_cycles/done/timeout, and enter HOLD with the hold counter restarted, all on the next edge.
REQ-019 SHALL ignore sw_rst_req in RESET.
REQ-020 SHALL register all outputs (no combinational paths from inputs to outputs).

Reset
REQ-021 SHALL, while rst=0, asynchronously force dom_rst to all-ones, state=RESET, run_cycles=0, done=0, timeout=0, and clear all counters.
REQ-022 SHALL deassert reset internally only through the SYNC_STAGES synchronizer; rst low mid-sequence at any state restores REQ-021 values immediately.

Structure
REQ-023 SHALL take the state enumeration and its 3-bit encoding (RESET=0, HOLD=1, RELEASE=2, RUN=3, END=4) from the shared package rst_ctrl_pkg.
REQ-024 SHALL implement the release synchronizer as sub-module rst_sync (parameter STAGES; async assert, synchronous deassert).
REQ-025 SHALL size internal counters with $clog2 of the largest of HOLD_CYCLES, STAGGER_CYCLES, plus one.

Verification (defaults; edge 0 = first edge after rst rises)
REQ-026 SHALL check nominal sequence: state=HOLD after edge 1; dom_rst[0] low after edge 11, [1] after 15, [2] after 19; state=RUN after 19.
REQ-027 SHALL check timeout: run_done held 0 -> timeout=1, state=END, run_cycles=500 after edge 519; done=0.
REQ-028 SHALL check completion: run_done=1 sampled on the 40th RUN edge -> done=1, run_cycles=40, timeout=0, all dom_rst=0.
REQ-029 SHALL check sw_rst_req pulse mid-RELEASE (edge 13) -> dom_rst=3'b111 and state=HOLD after edge 13; dom_rst[0] low after edge 23.
REQ-030 SHALL check async reset: rst low mid-RUN, between edges -> dom_rst=3'b111, state=RESET with no clk edge; rst 1-cycle glitch recovers via full sequence.
REQ-031 SHALL check parameter variants NUM_DOMAINS=1, TIMEOUT_CYCLES=0: RUN reached after edge 11, no timeout after 10000 RUN edges.
